// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the writeback path.
package regfile_pkg;

  localparam int RF_AW        = 5;
  localparam int RF_DW        = 32;
  localparam int RF_ZERO_ADDR = 0;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  typedef struct packed {
    rf_addr_t addr;
    rf_data_t data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; the pointer moves past the winner on each grant.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] nxt_ptr;

  // Scan offsets high to low so the smallest offset from rr_ptr wins last.
  always_comb begin
    int idx;
    gnt     = '0;
    nxt_ptr = rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (en && req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        nxt_ptr  = PW'((idx + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (en && |gnt) begin
      rr_ptr <= nxt_ptr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter driving the register file's single write port from one output stage.
// Optional build macro REGFILE_WB_ZERO_DROP_EN: accept but discard writes to register 0.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic              rf_stall,
  output logic              rf_we,
  output logic [AW-1:0]     rf_wa,
  output logic [DW-1:0]     rf_wd,
  input  logic [AW-1:0]     chk_addr,
  output logic              chk_hit
);

  // Handshake: request i transfers on a cycle where req_valid[i] && req_ready[i];
  // ready never looks at addr/data, and a waiting requester holds valid, addr and data.
  logic            stage_valid;
  logic            free;
  logic            load;
  logic [NREQ-1:0] gnt;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  assign free = !stage_valid || !rf_stall;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req_valid),
    .en      (free && reset_n),
    .gnt     (gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

`ifdef REGFILE_WB_ZERO_DROP_EN
  assign load = |gnt && (sel_addr != AW'(RF_ZERO_ADDR));
`else
  assign load = |gnt;
`endif

  // A load while draining simply overwrites the stage, giving back-to-back writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= 1'b0;
      rf_wa       <= '0;
      rf_wd       <= '0;
    end else if (load) begin
      stage_valid <= 1'b1;
      rf_wa       <= sel_addr;
      rf_wd       <= sel_data;
    end else if (free) begin
      stage_valid <= 1'b0;
    end
  end

  assign rf_we   = stage_valid;
  assign chk_hit = stage_valid && (rf_wa == chk_addr) && (chk_addr != AW'(RF_ZERO_ADDR));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file on the write port.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              clock;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              rf_stall;
  logic              rf_we;
  logic [AW-1:0]     rf_wa;
  logic [DW-1:0]     rf_wd;
  logic [AW-1:0]     chk_addr;
  logic              chk_hit;

  int errors;
  int checks;

  logic [DW-1:0] mem [32];

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_stall  (rf_stall),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .chk_addr  (chk_addr),
    .chk_hit   (chk_hit)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: commits on the edge when the port is written and not stalled; $0 stays zero.
  always @(posedge clock) begin
    if (rf_we && !rf_stall && rf_wa != '0) mem[rf_wa] <= rf_wd;
  end

  // Requester hold rule: a waiting request keeps valid, addr and data until accepted.
  logic [NREQ-1:0]    wait_q;
  logic [NREQ*AW-1:0] addr_q;
  logic [NREQ*DW-1:0] data_q;
  always @(posedge clock) begin
    if (reset_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (wait_q[i]) begin
          assert (req_valid[i] && req_addr[i*AW +: AW] == addr_q[i*AW +: AW]
                  && req_data[i*DW +: DW] == data_q[i*DW +: DW])
            else $error("FAIL hold_rule req%0d changed while waiting", i);
        end
      end
    end
    wait_q <= reset_n ? (req_valid & ~req_ready) : '0;
    addr_q <= req_addr;
    data_q <= req_data;
  end

  // driver tasks
  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]        = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clr_req(input int i);
    req_valid[i]        = 1'b0;
    req_addr[i*AW +: AW] = '0;
    req_data[i*DW +: DW] = '0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rf_stall  = 1'b0;
    chk_addr  = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (2) @(negedge clock);
    set_req(0, 5'd1, 32'h1);
    set_req(1, 5'd2, 32'h2);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_ready got=%b exp=00", req_ready);
    end
    checks++;
    if (rf_we !== 1'b0 || rf_wa !== '0 || rf_wd !== '0) begin
      errors++; $display("FAIL reset_port got we=%b wa=%0d wd=%h exp 0/0/0", rf_we, rf_wa, rf_wd);
    end
    checks++;
    if (chk_hit !== 1'b0) begin
      errors++; $display("FAIL reset_chk_hit got=%b exp=0", chk_hit);
    end
    @(negedge clock);
    clr_req(0);
    clr_req(1);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_write();
    set_req(0, 5'd12, 32'd69);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL single_ready got=%b exp=01", req_ready);
    end
    @(negedge clock);
    clr_req(0);
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd12 || rf_wd !== 32'd69) begin
      errors++; $display("FAIL single_port got we=%b wa=%0d wd=%0d exp 1/12/69", rf_we, rf_wa, rf_wd);
    end
    @(negedge clock);
    checks++;
    if (rf_we !== 1'b0) begin
      errors++; $display("FAIL single_drain got we=%b exp=0", rf_we);
    end
    checks++;
    if (mem[12] !== 32'd69) begin
      errors++; $display("FAIL single_commit got=%0d exp=69", mem[12]);
    end
  endtask

  // Entered with rr_ptr at 1 after the single write; req1 wins and moves it back to 0.
  task automatic test_hazard();
    set_req(1, 5'd9, 32'h99);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL hazard_ready got=%b exp=10", req_ready);
    end
    @(negedge clock);
    clr_req(1);
    chk_addr = 5'd9;
    #1;
    checks++;
    if (chk_hit !== 1'b1) begin
      errors++; $display("FAIL hazard_hit9 got=%b exp=1", chk_hit);
    end
    chk_addr = 5'd8;
    #1;
    checks++;
    if (chk_hit !== 1'b0) begin
      errors++; $display("FAIL hazard_miss8 got=%b exp=0", chk_hit);
    end
    @(negedge clock);
    chk_addr = 5'd9;
    #1;
    checks++;
    if (chk_hit !== 1'b0) begin
      errors++; $display("FAIL hazard_empty got=%b exp=0", chk_hit);
    end
    chk_addr = '0;
  endtask

  task automatic test_round_robin();
    logic [1:0]    exp_rdy [4];
    logic [AW-1:0] exp_wa  [4];
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
    exp_wa[0]  = 5'd3;  exp_wa[1]  = 5'd5;  exp_wa[2]  = 5'd4;  exp_wa[3]  = 5'd6;
    set_req(0, 5'd3, 32'd10);
    set_req(1, 5'd5, 32'd20);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (req_ready !== exp_rdy[c]) begin
        errors++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", c, req_ready, exp_rdy[c]);
      end
      @(negedge clock);
      if (c == 0) set_req(0, 5'd4, 32'd11);
      if (c == 1) set_req(1, 5'd6, 32'd21);
      if (c == 2) clr_req(0);
      if (c == 3) clr_req(1);
      #1;
      checks++;
      if (rf_we !== 1'b1 || rf_wa !== exp_wa[c]) begin
        errors++; $display("FAIL rr_wa cycle=%0d got we=%b wa=%0d exp wa=%0d", c, rf_we, rf_wa, exp_wa[c]);
      end
    end
    @(negedge clock);
    checks++;
    if (mem[3] !== 32'd10 || mem[5] !== 32'd20 || mem[4] !== 32'd11 || mem[6] !== 32'd21) begin
      errors++; $display("FAIL rr_commit got %0d %0d %0d %0d exp 10 20 11 21", mem[3], mem[5], mem[4], mem[6]);
    end
  endtask

  task automatic test_stall();
    set_req(0, 5'd7, 32'hDEAD);
    @(negedge clock);
    clr_req(0);
    set_req(1, 5'd8, 32'hBEEF);
    rf_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
        errors++; $display("FAIL stall_ready cycle=%0d got=%b exp=00", k, req_ready);
      end
      checks++;
      if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'hDEAD) begin
        errors++; $display("FAIL stall_hold cycle=%0d got we=%b wa=%0d wd=%h exp 1/7/dead", k, rf_we, rf_wa, rf_wd);
      end
      @(negedge clock);
    end
    checks++;
    if (mem[7] !== 32'd0) begin
      errors++; $display("FAIL stall_nocommit got=%h exp=0", mem[7]);
    end
    rf_stall = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL stall_release_ready got=%b exp=10", req_ready);
    end
    @(negedge clock);
    clr_req(1);
    #1;
    checks++;
    if (rf_wa !== 5'd8 || rf_wd !== 32'hBEEF || mem[7] !== 32'hDEAD) begin
      errors++; $display("FAIL stall_next got wa=%0d wd=%h mem7=%h exp 8/beef/dead", rf_wa, rf_wd, mem[7]);
    end
    @(negedge clock);
  endtask

  task automatic test_zero_write();
    set_req(0, 5'd0, 32'd69);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL zero_ready got=%b exp=01", req_ready);
    end
    @(negedge clock);
    clr_req(0);
    chk_addr = 5'd0;
    #1;
`ifdef REGFILE_WB_ZERO_DROP_EN
    checks++;
    if (rf_we !== 1'b0) begin
      errors++; $display("FAIL zero_dropped got we=%b exp=0", rf_we);
    end
`else
    checks++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd0 || rf_wd !== 32'd69) begin
      errors++; $display("FAIL zero_pass got we=%b wa=%0d wd=%0d exp 1/0/69", rf_we, rf_wa, rf_wd);
    end
`endif
    checks++;
    if (chk_hit !== 1'b0) begin
      errors++; $display("FAIL zero_chk_hit got=%b exp=0", chk_hit);
    end
    @(negedge clock);
  endtask

  // Entered with rr_ptr at 1, so the post-reset grant to req0 shows the pointer was cleared.
  task automatic test_reset_mid();
    set_req(0, 5'd15, 32'd5);
    @(negedge clock);
    clr_req(0);
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd15) begin
      errors++; $display("FAIL mid_staged got we=%b wa=%0d exp 1/15", rf_we, rf_wa);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (rf_we !== 1'b0 || rf_wa !== '0 || rf_wd !== '0) begin
      errors++; $display("FAIL mid_async got we=%b wa=%0d wd=%0d exp 0/0/0", rf_we, rf_wa, rf_wd);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (mem[15] !== 32'd0) begin
      errors++; $display("FAIL mid_nocommit got=%0d exp=0", mem[15]);
    end
    reset_n = 1'b1;
    set_req(0, 5'd20, 32'd1);
    set_req(1, 5'd21, 32'd2);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL mid_first_grant got=%b exp=01", req_ready);
    end
    @(negedge clock);
    clr_req(0);
    @(negedge clock);
    clr_req(1);
    repeat (2) @(negedge clock);
    checks++;
    if (mem[20] !== 32'd1 || mem[21] !== 32'd2) begin
      errors++; $display("FAIL mid_after got %0d %0d exp 1 2", mem[20], mem[21]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_write();
    test_hazard();
    test_round_robin();
    test_stall();
    test_zero_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
